// File: rtl/rf_dump_reader_if.sv
// Stream side of rf_dump_reader: one register-dump beat (index + data) per valid/ready handshake.
interface rf_dump_reader_if;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_idx, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_idx, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/rf_dump_reader.sv
// Walks the RF inspection port from FIRST_REG to LAST_REG and streams each word out.
// Define RF_DUMP_CHKSUM_EN to append an XOR checksum beat (m_idx=0, m_last=1).
module rf_dump_reader #(
  parameter int unsigned FIRST_REG  = 1,
  parameter int unsigned LAST_REG   = 31,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [4:0]        reg_sel,
  input  logic [31:0]       reg_data,
  rf_dump_reader_if.master  m,
  output logic              busy,
  output logic              done
);

  if (FIRST_REG > LAST_REG || LAST_REG > 31 || GAP_CYCLES > 255) begin : g_param_check
    $error("rf_dump_reader: invalid FIRST_REG/LAST_REG/GAP_CYCLES");
  end

  localparam logic [4:0] FIRST5   = 5'(FIRST_REG);
  localparam logic [4:0] LAST5    = 5'(LAST_REG);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
`ifdef RF_DUMP_CHKSUM_EN
  localparam logic DATA_LAST = 1'b0;
`else
  localparam logic DATA_LAST = 1'b1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    VALID,
    GAP,
`ifdef RF_DUMP_CHKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t      state, state_nxt, after_beat;
  logic [4:0]  sel_q;
  logic        valid_q;
  logic [4:0]  idx_q;
  logic [31:0] data_q;
  logic        last_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  gap_q;
`ifdef RF_DUMP_CHKSUM_EN
  logic [31:0] chk_q;
`endif

  logic accept;
  assign accept = valid_q & m.m_ready;

  // Destination once a data beat and its trailing gap are complete.
  always_comb begin
    after_beat = SEL;
    if (sel_q == LAST5) begin
`ifdef RF_DUMP_CHKSUM_EN
      after_beat = CHK;
`else
      after_beat = DONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SEL;
      SEL:   state_nxt = VALID;
      VALID: if (accept) state_nxt = (GAP_CYCLES > 0) ? GAP : after_beat;
      GAP:   if (gap_q == '0) state_nxt = after_beat;
`ifdef RF_DUMP_CHKSUM_EN
      CHK:   if (accept) state_nxt = DONE;
`endif
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
`ifdef RF_DUMP_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          sel_q <= FIRST5;
`ifdef RF_DUMP_CHKSUM_EN
          chk_q <= '0;
`endif
        end
        SEL: begin
          data_q  <= reg_data;
          idx_q   <= sel_q;
          last_q  <= DATA_LAST & (sel_q == LAST5);
          valid_q <= 1'b1;
        end
        VALID: if (accept) begin
          valid_q <= 1'b0;
          gap_q   <= GAP_LOAD;
`ifdef RF_DUMP_CHKSUM_EN
          chk_q   <= chk_q ^ data_q;
`endif
        end
        GAP: if (gap_q != '0) gap_q <= gap_q - 8'd1;
`ifdef RF_DUMP_CHKSUM_EN
        CHK: begin
          if (!valid_q) begin
            data_q  <= chk_q;
            idx_q   <= '0;
            last_q  <= 1'b1;
            valid_q <= 1'b1;
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
      // Only VALID/GAP can lead into SEL here, so this never runs past LAST_REG.
      if (state_nxt == SEL && state != IDLE) sel_q <= sel_q + 5'd1;
      if (abort && state != IDLE) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        sel_q   <= '0;
      end
    end
  end

  assign reg_sel  = sel_q;
  assign m.m_valid = valid_q;
  assign m.m_idx   = idx_q;
  assign m.m_data  = data_q;
  assign m.m_last  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: three parameterisations against a beat-list reference model.
module tb_rf_dump_reader;

`ifdef RF_DUMP_CHKSUM_EN
  localparam int unsigned CHK = 1;
`else
  localparam int unsigned CHK = 0;
`endif
  localparam int unsigned FIRST_A [3] = '{1, 0, 7};
  localparam int unsigned LAST_A  [3] = '{31, 6, 7};
  localparam int unsigned GAP_A   [3] = '{0, 3, 0};

  logic        clk;
  logic        rst;
  logic        start_v [3];
  logic        abort_v [3];
  logic        ready_v [3];
  logic [4:0]  sel_o   [3];
  logic [31:0] rdata   [3];
  logic        valid_o [3];
  logic [4:0]  idx_o   [3];
  logic [31:0] data_o  [3];
  logic        last_o  [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [31:0] rf      [32];
  int          total, bad;

  rf_dump_reader_if m_if0 ();
  rf_dump_reader_if m_if1 ();
  rf_dump_reader_if m_if2 ();

  rf_dump_reader #(.FIRST_REG(1), .LAST_REG(31), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .reg_sel(sel_o[0]),
    .reg_data(rdata[0]), .m(m_if0), .busy(busy_o[0]), .done(done_o[0]));
  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(6), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .reg_sel(sel_o[1]),
    .reg_data(rdata[1]), .m(m_if1), .busy(busy_o[1]), .done(done_o[1]));
  rf_dump_reader #(.FIRST_REG(7), .LAST_REG(7), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .reg_sel(sel_o[2]),
    .reg_data(rdata[2]), .m(m_if2), .busy(busy_o[2]), .done(done_o[2]));

  // Register file inspection port: combinational, x0 reads as zero.
  assign rdata[0] = (sel_o[0] == 5'd0) ? 32'd0 : rf[sel_o[0]];
  assign rdata[1] = (sel_o[1] == 5'd0) ? 32'd0 : rf[sel_o[1]];
  assign rdata[2] = (sel_o[2] == 5'd0) ? 32'd0 : rf[sel_o[2]];

  assign m_if0.m_ready = ready_v[0];
  assign m_if1.m_ready = ready_v[1];
  assign m_if2.m_ready = ready_v[2];
  assign valid_o[0] = m_if0.m_valid;
  assign valid_o[1] = m_if1.m_valid;
  assign valid_o[2] = m_if2.m_valid;
  assign idx_o[0] = m_if0.m_idx;
  assign idx_o[1] = m_if1.m_idx;
  assign idx_o[2] = m_if2.m_idx;
  assign data_o[0] = m_if0.m_data;
  assign data_o[1] = m_if1.m_data;
  assign data_o[2] = m_if2.m_data;
  assign last_o[0] = m_if0.m_last;
  assign last_o[1] = m_if1.m_last;
  assign last_o[2] = m_if2.m_last;

  always #5 clk = ~clk;

  task automatic preload;
    rf[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < 32; i++) rf[i] = 32'h100 + 32'(i);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({valid_o[k], idx_o[k], data_o[k], last_o[k], sel_o[k], busy_o[k], done_o[k]} !== '0) begin
        bad++;
        $display("FAIL reset dut%0d: valid=%b idx=%0d data=%h last=%b sel=%0d busy=%b done=%b, want all 0",
                 k, valid_o[k], idx_o[k], data_o[k], last_o[k], sel_o[k], busy_o[k], done_o[k]);
      end
    end
    rst = 1'b0;
  endtask

  // One full dump on dut k, comparing every accepted beat with the expected beat list.
  task automatic dump(input int k, input bit rnd, input bit timed, input bit with_abort);
    int unsigned ndata, nexp, got, cyc, idle, ei;
    logic [31:0] xsum, exp_d, h_d;
    logic [4:0]  exp_i, h_i;
    logic        exp_l, h_l, rdy;
    bit          hold, prev_v, fin;
    ndata = LAST_A[k] - FIRST_A[k] + 1;
    nexp  = ndata + CHK;
    got = 0; cyc = 0; idle = 0; ei = 0; xsum = '0; hold = 0; prev_v = 0; fin = 0;
    h_d = '0; h_i = '0; h_l = 1'b0;
    @(negedge clk);
    start_v[k] = 1'b1; abort_v[k] = with_abort; ready_v[k] = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start_v[k] = 1'b0; abort_v[k] = 1'b0;
      if (hold) begin
        total++;
        if (valid_o[k] !== 1'b1 || idx_o[k] !== h_i || data_o[k] !== h_d || last_o[k] !== h_l) begin
          bad++;
          $display("FAIL hold dut%0d: valid=%b idx=%0d data=%h last=%b, want valid=1 idx=%0d data=%h last=%b",
                   k, valid_o[k], idx_o[k], data_o[k], last_o[k], h_i, h_d, h_l);
        end
      end
      hold = 0;
      if (done_o[k] === 1'b1) begin
        fin = 1;
        total++;
        if (got != nexp) begin
          bad++;
          $display("FAIL done_count dut%0d: beats=%0d, want %0d", k, got, nexp);
        end
        if (timed) begin
          total++;
          if (cyc != 2 * nexp + 1) begin
            bad++;
            $display("FAIL done_latency dut%0d: cycles=%0d, want %0d", k, cyc, 2 * nexp + 1);
          end
        end
      end else begin
        total++;
        if (busy_o[k] !== 1'b1) begin
          bad++;
          $display("FAIL busy dut%0d: busy=%b, want 1 (cycle %0d)", k, busy_o[k], cyc);
        end
        if (valid_o[k] === 1'b1 && !prev_v) begin
          if (got == 0 && timed) begin
            total++;
            if (cyc != 2) begin
              bad++;
              $display("FAIL first_latency dut%0d: cycles=%0d, want 2", k, cyc);
            end
          end
          if (got > 0) begin
            total++;
            if (idle < GAP_A[k]) begin
              bad++;
              $display("FAIL gap dut%0d: idle=%0d, want >=%0d", k, idle, GAP_A[k]);
            end
          end
        end
        prev_v = (valid_o[k] === 1'b1);
        rdy = rnd ? 1'($urandom_range(1)) : 1'b1;
        ready_v[k] = rdy;
        if (rnd && $urandom_range(3) == 0) start_v[k] = 1'b1;
        if (valid_o[k] === 1'b1 && rdy) begin
          if (got < ndata) begin
            ei    = FIRST_A[k] + got;
            exp_i = 5'(ei);
            exp_d = (ei == 0) ? 32'd0 : rf[5'(ei)];
            exp_l = (CHK == 0) && (got == ndata - 1);
            xsum  = xsum ^ exp_d;
          end else begin
            exp_i = '0; exp_d = xsum; exp_l = 1'b1;
          end
          total++;
          if (idx_o[k] !== exp_i || data_o[k] !== exp_d || last_o[k] !== exp_l) begin
            bad++;
            $display("FAIL beat%0d dut%0d: idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     got, k, idx_o[k], data_o[k], last_o[k], exp_i, exp_d, exp_l);
          end
          got++;
          idle = 0;
          // Writes land only on registers not yet selected, so the model stays exact.
          if (rnd && got <= ndata && ei + 2 <= LAST_A[k] && $urandom_range(2) == 0)
            rf[5'(ei + 2)] = $urandom;
        end else if (valid_o[k] === 1'b1) begin
          hold = 1; h_i = idx_o[k]; h_d = data_o[k]; h_l = last_o[k];
        end else begin
          idle++;
        end
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout dut%0d: beats=%0d, want %0d before budget", k, got, nexp);
    end else begin
      @(negedge clk);
      total++;
      if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0 || valid_o[k] !== 1'b0) begin
        bad++;
        $display("FAIL done_pulse dut%0d: done=%b busy=%b valid=%b, want 0 0 0", k, done_o[k], busy_o[k], valid_o[k]);
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy_o[k] !== 1'b0 || valid_o[k] !== 1'b0) begin
        bad++;
        $display("FAIL no_restart dut%0d: busy=%b valid=%b, want 0 0", k, busy_o[k], valid_o[k]);
      end
    end
    ready_v[k] = 1'b0;
  endtask

  task automatic test_full_dump;
    preload();
    dump(0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random_ready;
    dump(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_gap;
    dump(1, 1'b0, 1'b0, 1'b0);
    dump(1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_single_reg;
    dump(2, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_abort;
    int  cyc;
    bit  hit, saw_done;
    preload();
    cyc = 0; hit = 0; saw_done = 0;
    @(negedge clk);
    start_v[0] = 1'b1; ready_v[0] = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start_v[0] = 1'b0;
      if (valid_o[0] === 1'b1 && idx_o[0] === 5'd5) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL abort_reach: idx=%0d, want beat idx 5 within budget", idx_o[0]);
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    total++;
    if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || last_o[0] !== 1'b0 || sel_o[0] !== 5'd0 || done_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: valid=%b busy=%b last=%b sel=%0d done=%b, want 0 0 0 0 0",
               valid_o[0], busy_o[0], last_o[0], sel_o[0], done_o[0]);
    end
    repeat (5) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL abort_done: done=1 seen, want none");
    end
    ready_v[0] = 1'b0;
    dump(0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset;
    int cyc;
    cyc = 0;
    @(negedge clk);
    start_v[0] = 1'b1; ready_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (valid_o[0] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (valid_o[0] !== 1'b1 || idx_o[0] !== 5'd1) begin
      bad++;
      $display("FAIL rst_setup: valid=%b idx=%0d, want 1 1", valid_o[0], idx_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({valid_o[0], idx_o[0], data_o[0], last_o[0], sel_o[0], busy_o[0], done_o[0]} !== '0) begin
      bad++;
      $display("FAIL async_reset: valid=%b idx=%0d data=%h last=%b sel=%0d busy=%b done=%b, want all 0",
               valid_o[0], idx_o[0], data_o[0], last_o[0], sel_o[0], busy_o[0], done_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    preload();
    dump(2, 1'b0, 1'b1, 1'b0);
    dump(2, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; abort_v[k] = 1'b0; ready_v[k] = 1'b0;
    end
    preload();
    test_reset();
    test_full_dump();
    test_random_ready();
    test_gap();
    test_single_reg();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
